// File: rtl/hilo_mul_ctrl_if.sv
// EX-side and multiplier-side signals of hilo_mul_ctrl; EX drives the request, stall throttles it.
// Zero latency bundle; stall is the only backpressure and EX must hold while it is high.
interface hilo_mul_ctrl_if;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mul_start;
  logic        mul_op;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] product;

  modport master (
    output ex_valid, ex_op, ex_rs, ex_rt, ex_flush, product,
    input  stall, hi_out, lo_out, mul_start, mul_op, mul_op1, mul_op2
  );

  modport slave (
    input  ex_valid, ex_op, ex_rs, ex_rt, ex_flush, product,
    output stall, hi_out, lo_out, mul_start, mul_op, mul_op1, mul_op2
  );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO owner driving a MUL_LAT-cycle multiplier; MULT retires after MUL_LAT cycles, MADD/MSUB after MUL_LAT+1.
// Backpressure: stall holds EX while an op is in flight; flush kills it at once with no HI/LO write.
module hilo_mul_ctrl #(
  parameter int MUL_LAT = 5
) (
  input logic           clk,
  input logic           reset,
  hilo_mul_ctrl_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic        acc_op, sub_op;
  logic [63:0] preg;
  logic [31:0] hi_q, lo_q;
  logic        mul_start_q, mul_op_q;
  logic [31:0] mul_op1_q, mul_op2_q;
  logic        mult_cls, issue, last, stall_c;

  assign mult_cls = bus.ex_op inside {[4'd1:4'd6]};
  assign issue    = (state == IDLE) && bus.ex_valid && mult_cls && !bus.ex_flush;
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    if (bus.ex_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          stall_c = bus.ex_valid && mult_cls;
          if (issue) state_nxt = MUL;
        end
        MUL: begin
          // MADD-class keeps EX stalled through the product cycle; the ACC cycle is its release.
          stall_c = acc_op || !last;
          if (last) state_nxt = acc_op ? ACC : IDLE;
        end
        ACC:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    if (!reset) stall_c = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      acc_op      <= 1'b0;
      sub_op      <= 1'b0;
      preg        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mul_start_q <= 1'b0;
      mul_op_q    <= 1'b0;
      mul_op1_q   <= '0;
      mul_op2_q   <= '0;
    end else if (bus.ex_flush) begin
      cnt         <= '0;
      mul_start_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            mul_op1_q   <= bus.ex_rs;
            mul_op2_q   <= bus.ex_rt;
            mul_op_q    <= (bus.ex_op == 4'd1) || (bus.ex_op == 4'd3) || (bus.ex_op == 4'd5);
            mul_start_q <= 1'b1;
            cnt         <= CW'(MUL_LAT);
            acc_op      <= bus.ex_op >= 4'd3;
            sub_op      <= bus.ex_op >= 4'd5;
          end else if (bus.ex_valid && bus.ex_op == 4'd7) begin
            hi_q <= bus.ex_rs;
          end else if (bus.ex_valid && bus.ex_op == 4'd8) begin
            lo_q <= bus.ex_rs;
          end
        end
        MUL: begin
          cnt <= cnt - CW'(1);
          if (last) begin
            mul_start_q <= 1'b0;
            if (acc_op) preg <= bus.product;
            else        {hi_q, lo_q} <= bus.product;
          end
        end
        ACC: begin
          {hi_q, lo_q} <= sub_op ? ({hi_q, lo_q} - preg) : ({hi_q, lo_q} + preg);
        end
        default: ;
      endcase
    end
  end

  assign bus.stall     = stall_c;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_op    = mul_op_q;
  assign bus.mul_op1   = mul_op1_q;
  assign bus.mul_op2   = mul_op2_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Scoreboarded bench for hilo_mul_ctrl: directed cases, random op stream with flushes, async reset abort.
module tb_hilo_mul_ctrl;
  localparam int MUL_LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  hilo_mul_ctrl_if bus ();

  hilo_mul_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall_cyc;
    int          start_cyc;
    bit          chk_op;
    logic        op_s;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: exact product only in the MUL_LAT-th cycle of mul_start, garbage otherwise.
  int          hcnt = 0;
  logic [63:0] ma, mb;
  always @(posedge clk) begin
    #1;
    if (bus.mul_start) hcnt++;
    else hcnt = 0;
    ma = bus.mul_op ? {{32{bus.mul_op1[31]}}, bus.mul_op1} : {32'b0, bus.mul_op1};
    mb = bus.mul_op ? {{32{bus.mul_op2[31]}}, bus.mul_op2} : {32'b0, bus.mul_op2};
    if (bus.mul_start && hcnt == MUL_LAT) bus.product = ma * mb;
    else bus.product = {$urandom, $urandom};
  end

  // Monitor: an instruction leaves EX on any cycle with ex_valid and no stall.
  int   st_cnt = 0;
  int   ms_cnt = 0;
  bit   pend = 1'b0;
  exp_t pe, ce;
  always @(negedge clk) begin
    if (!reset) begin
      st_cnt = 0;
      ms_cnt = 0;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        chk("hi_out", bus.hi_out, pe.hi);
        chk("lo_out", bus.lo_out, pe.lo);
        pend = 1'b0;
      end
      if (bus.stall) st_cnt++;
      if (bus.mul_start) ms_cnt++;
      if (bus.ex_valid && !bus.stall) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got retirement expected none");
        end else begin
          ce = sb.pop_front();
          chk("stall_cycles", st_cnt, ce.stall_cyc);
          chk("mul_start_cycles", ms_cnt, ce.start_cyc);
          if (ce.chk_op) begin
            chk("mul_op", bus.mul_op, ce.op_s);
            chk("mul_op1", bus.mul_op1, ce.op1);
            chk("mul_op2", bus.mul_op2, ce.op2);
          end
          pe   = ce;
          pend = 1'b1;
        end
        st_cnt = 0;
        ms_cnt = 0;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the instruction has left EX.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int flush_at);
    exp_t        e;
    bit          mc, ac, killed, done;
    int          slen;
    logic [63:0] a, b, p, hl;
    mc     = (op >= 1 && op <= 6);
    ac     = (op >= 3 && op <= 6);
    e.op_s = (op == 1 || op == 3 || op == 5);
    slen   = !mc ? 0 : (ac ? MUL_LAT + 1 : MUL_LAT);
    killed = (flush_at >= 0) && (flush_at <= slen);
    e.stall_cyc = killed ? flush_at : slen;
    e.start_cyc = !mc ? 0 : (killed ? ((flush_at < MUL_LAT) ? flush_at : MUL_LAT) : MUL_LAT);
    e.chk_op    = mc && !(killed && flush_at == 0);
    e.op1 = rs;
    e.op2 = rt;
    a  = e.op_s ? {{32{rs[31]}}, rs} : {32'b0, rs};
    b  = e.op_s ? {{32{rt[31]}}, rt} : {32'b0, rt};
    p  = a * b;
    hl = {m_hi, m_lo};
    if (!killed) begin
      if (op == 1 || op == 2) hl = p;
      else if (op == 3 || op == 4) hl = hl + p;
      else if (op == 5 || op == 6) hl = hl - p;
      {m_hi, m_lo} = hl;
      if (op == 7) m_hi = rs;
      if (op == 8) m_lo = rs;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);

    bus.ex_valid = 1'b1;
    bus.ex_op    = op;
    bus.ex_rs    = rs;
    bus.ex_rt    = rt;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.ex_flush = (c == flush_at);
      @(negedge clk);
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL stall_timeout: got stall stuck expected release within 40 cycles");
    end
    bus.ex_valid = 1'b0;
    bus.ex_flush = 1'b0;
    bus.ex_op    = 4'($urandom);
    bus.ex_rs    = $urandom;
    bus.ex_rt    = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.ex_valid = 1'b0;
    bus.ex_op    = 4'd0;
    bus.ex_rs    = '0;
    bus.ex_rt    = '0;
    bus.ex_flush = 1'b0;
    bus.product  = '0;
    #2 reset = 1'b0;
    #20;
    chk("rst_hi", bus.hi_out, 32'h0);
    chk("rst_lo", bus.lo_out, 32'h0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_mul_start", bus.mul_start, 1'b0);
    chk("rst_mul_op", bus.mul_op, 1'b0);
    chk("rst_mul_ops", {bus.mul_op1, bus.mul_op2}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, -1);
    chk("mult_hi", bus.hi_out, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo_out, 32'hFFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, -1);
    chk("multu_hi", bus.hi_out, 32'h00000001);
    chk("multu_op", bus.mul_op, 1'b0);
    run_op(4'd7, 32'h0, 32'h0, -1);
    run_op(4'd8, 32'hFFFFFFFF, 32'h0, -1);
    run_op(4'd4, 32'd1, 32'd1, -1);
    chk("maddu_hilo", {bus.hi_out, bus.lo_out}, 64'h00000001_00000000);
    run_op(4'd7, 32'h0, 32'h0, -1);
    run_op(4'd8, 32'h0, 32'h0, -1);
    run_op(4'd5, 32'd3, 32'd1, -1);
    chk("msub_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd7, 32'h12345678, 32'h0, -1);
    run_op(4'd1, 32'd7, 32'd9, 3);
    chk("flush_hi", bus.hi_out, 32'h12345678);
    run_op(4'd1, 32'd7, 32'd9, -1);
    chk("mult_after_flush_lo", bus.lo_out, 32'd63);
    run_op(4'd1, 32'd3, 32'd5, MUL_LAT);
    run_op(4'd3, 32'd3, 32'd5, MUL_LAT + 1);
    run_op(4'd6, 32'd3, 32'd5, 0);
    run_op(4'd9, 32'd1, 32'd1, -1);
    run_op(4'd0, 32'd1, 32'd1, -1);

    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1);
      idle($urandom_range(0, 2));
    end

    run_op(4'd7, 32'hA5A5A5A5, 32'h0, -1);
    idle(2);
    bus.ex_valid = 1'b1;
    bus.ex_op    = 4'd2;
    bus.ex_rs    = 32'd11;
    bus.ex_rt    = 32'd13;
    idle(2);
    chk("pre_reset_mul_start", bus.mul_start, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_mul_start", bus.mul_start, 1'b0);
    chk("async_rst_stall", bus.stall, 1'b0);
    chk("async_rst_hilo", {bus.hi_out, bus.lo_out}, 64'h0);
    bus.ex_valid = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);
    run_op(4'd8, 32'd5, 32'd0, -1);
    chk("mtlo_after_reset", bus.lo_out, 32'd5);
    idle(3);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
